// File: rtl/udp_tx_pkt_buf.sv
// udp_tx_pkt_buf: circular byte buffer that gathers UDP payload packets,
// discards packets that do not fit, and streams committed packets to the framer.
module udp_tx_pkt_buf #(
  parameter int  ADDR_WIDTH     = 11,
  parameter int  LEN_FIFO_DEPTH = 4,
  localparam int LEN_W          = ADDR_WIDTH + 1,
  localparam int CNT_W          = $clog2(LEN_FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  input  logic             wr_last,
  output logic             wr_drop,
  output logic [LEN_W-1:0] buf_free,
  output logic             pkt_rdy,
  output logic [LEN_W-1:0] pkt_len,
  output logic [CNT_W-1:0] pkt_cnt,
  input  logic             rd_req,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_last,
  input  logic             tx_ready
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int FP_W  = (LEN_FIFO_DEPTH > 1) ? $clog2(LEN_FIFO_DEPTH) : 1;
  localparam logic [LEN_W-1:0] BUF_BYTES = LEN_W'(DEPTH);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(LEN_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} rd_state_t;

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wp, sp, rp;
  logic [LEN_W-1:0]      cur_len, rd_cnt;
  logic                  drop_q;
  logic [7:0]            mem [DEPTH];
  logic [7:0]            rd_data_p1;
  logic [LEN_W-1:0]      len_mem [LEN_FIFO_DEPTH];
  logic [FP_W-1:0]       f_wp, f_rp;
  logic [CNT_W-1:0]      f_cnt;
  logic                  fifo_full, fifo_empty;
  logic                  wr_ovf, wr_store, wr_commit, wr_abort;
  logic                  rd_en, tx_hs, rel;

  function automatic logic [FP_W-1:0] fifo_inc(input logic [FP_W-1:0] p);
    return (p == FP_W'(LEN_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (f_cnt == FIFO_FULL);
  assign fifo_empty = (f_cnt == '0);
  assign pkt_rdy    = !fifo_empty;
  assign pkt_cnt    = f_cnt;
  assign pkt_len    = fifo_empty ? '0 : len_mem[f_rp];

  // A byte that finds no room, or a packet end with no free length slot, aborts the packet.
  always_comb begin
    wr_ovf    = (buf_free == '0) || (wr_last && fifo_full);
    wr_store  = wr_en && !drop_q && !wr_ovf;
    wr_commit = wr_store && wr_last;
    wr_abort  = wr_en && !drop_q && wr_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      sp      <= '0;
      cur_len <= '0;
      drop_q  <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= 1'b0;
      if (wr_abort) begin
        wp      <= sp;
        cur_len <= '0;
        drop_q  <= !wr_last;
        wr_drop <= wr_last;
      end else if (wr_store) begin
        wp <= wp + 1'b1;
        if (wr_last) begin
          sp      <= wp + 1'b1;
          cur_len <= '0;
        end else begin
          cur_len <= cur_len + 1'b1;
        end
      end else if (drop_q && wr_en && wr_last) begin
        drop_q  <= 1'b0;
        wr_drop <= 1'b1;
      end
    end
  end

  // Reservation, abort refund and release may all land in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) buf_free <= BUF_BYTES;
    else     buf_free <= buf_free - LEN_W'(wr_store) + (wr_abort ? cur_len : '0)
                         + (rel ? pkt_len : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_wp  <= '0;
      f_rp  <= '0;
      f_cnt <= '0;
    end else begin
      if (wr_commit) f_wp <= fifo_inc(f_wp);
      if (rel)       f_rp <= fifo_inc(f_rp);
      f_cnt <= f_cnt + CNT_W'(wr_commit) - CNT_W'(rel);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_commit) len_mem[f_wp] <= cur_len + 1'b1;
  end

  // Stage p1: RAM read register; it holds its value while no read is issued (stall).
  always_ff @(posedge clk) begin
    if (wr_store) mem[wp] <= wr_data;
    if (rd_en)    rd_data_p1 <= mem[rp];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_req && pkt_rdy) state_d = FETCH;
      FETCH:   state_d = SEND;
      SEND:    if (rel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The next byte is read in the same cycle the current one is accepted, so no bubbles.
  always_comb begin
    tx_valid = (state_q == SEND);
    tx_last  = tx_valid && (rd_cnt == LEN_W'(1));
    tx_hs    = tx_valid && tx_ready;
    rel      = tx_hs && tx_last;
    rd_en    = (state_q == FETCH) || (tx_hs && !tx_last);
    tx_data  = tx_valid ? rd_data_p1 : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp     <= '0;
      rd_cnt <= '0;
    end else begin
      if (rd_en) rp <= rp + 1'b1;
      if (state_q == FETCH) rd_cnt <= pkt_len;
      else if (tx_hs)       rd_cnt <= rd_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_udp_tx_pkt_buf.sv
// Bench for udp_tx_pkt_buf: randomized packets checked against a queue model
// of committed bytes, packet lengths and free space.
`timescale 1ns/1ps
module tb_udp_tx_pkt_buf;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_en = 1'b0, wr_last = 1'b0, rd_req = 1'b0, tx_ready = 1'b0;
  logic        wr_drop, pkt_rdy, tx_valid, tx_last;
  logic [11:0] buf_free, pkt_len;
  logic [2:0]  pkt_cnt;
  logic [7:0]  tx_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_free  = 2048;
  int          m_lens[$];
  logic [7:0]  m_bytes[$];

  always #5 clk = ~clk;

  udp_tx_pkt_buf dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_last(wr_last),
    .wr_drop(wr_drop), .buf_free(buf_free), .pkt_rdy(pkt_rdy), .pkt_len(pkt_len),
    .pkt_cnt(pkt_cnt), .rd_req(rd_req), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_free = 2048;
    m_lens.delete();
    m_bytes.delete();
  endtask

  // mode 0: bytes base, base+1, ...; mode 1: random bytes
  task automatic write_pkt(input int len, input int mode, input logic [7:0] base);
    bit         acc;
    logic [7:0] b;
    acc = (len <= m_free) && (m_lens.size() < 4);
    for (int i = 0; i < len; i++) begin
      b = (mode == 0) ? base + 8'(i) : 8'($urandom);
      wr_en = 1'b1; wr_data = b; wr_last = (i == len - 1);
      if (acc) m_bytes.push_back(b);
      tick();
    end
    wr_en = 1'b0; wr_last = 1'b0;
    if (acc) begin
      m_lens.push_back(len);
      m_free -= len;
    end
    n_tests++;
    if (wr_drop !== !acc) begin
      n_fail++;
      $display("FAIL wr_drop_pulse: got %b want %b (len %0d)", wr_drop, !acc, len);
    end
    n_tests++;
    if (buf_free !== 12'(m_free) || pkt_cnt !== 3'(m_lens.size())) begin
      n_fail++;
      $display("FAIL after_write: buf_free %0d pkt_cnt %0d want %0d %0d",
               buf_free, pkt_cnt, m_free, m_lens.size());
    end
    tick();
    n_tests++;
    if (wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_drop_once: got %b want 0", wr_drop);
    end
  endtask

  // mode 0: tx_ready=1; 1: random ready and stray rd_req; 2: ready pattern 1,0,0
  task automatic read_pkt(input int mode);
    int         len, idx, cyc;
    logic [7:0] hold_d, exp_d;
    logic       hold_l, stalled;
    len = (m_lens.size() > 0) ? m_lens[0] : 0;
    n_tests++;
    if (pkt_rdy !== 1'b1 || pkt_len !== 12'(len)) begin
      n_fail++;
      $display("FAIL head_pkt: pkt_rdy %b pkt_len %0d want 1 %0d", pkt_rdy, pkt_len, len);
    end
    rd_req = 1'b1; tx_ready = (mode == 0);
    tick();
    rd_req = 1'b0;
    n_tests++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: tx_valid %b want 0", tx_valid);
    end
    tick();
    n_tests++;
    if (tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: tx_valid %b want 1", tx_valid);
    end
    idx = 0; cyc = 0; stalled = 1'b0; hold_d = 8'h00; hold_l = 1'b0;
    while (idx < len && cyc < 4 * len + 20) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom % 2);
        default: tx_ready = (cyc % 3 == 0);
      endcase
      if (mode == 1) rd_req = 1'($urandom % 2);
      if (stalled) begin
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== hold_d || tx_last !== hold_l) begin
          n_fail++;
          $display("FAIL stall_hold: v %b d %h l %b want 1 %h %b", tx_valid, tx_data, tx_last,
                   hold_d, hold_l);
        end
      end
      if (mode == 0) begin
        n_tests++;
        if (tx_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL no_bubble: tx_valid %b at byte %0d", tx_valid, idx);
        end
      end
      if (tx_valid && tx_ready) begin
        exp_d = m_bytes.pop_front();
        n_tests++;
        if (tx_data !== exp_d || tx_last !== (idx == len - 1)) begin
          n_fail++;
          $display("FAIL tx_byte %0d: data %h last %b want %h %b", idx, tx_data, tx_last, exp_d,
                   (idx == len - 1));
        end
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = tx_valid;
        hold_d  = tx_data;
        hold_l  = tx_last;
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b0; rd_req = 1'b0;
    n_tests++;
    if (idx < len) begin
      n_fail++;
      $display("FAIL read_timeout: got %0d bytes want %0d", idx, len);
      for (int i = idx; i < len; i++) void'(m_bytes.pop_front());
    end
    if (m_lens.size() > 0) void'(m_lens.pop_front());
    m_free += len;
    n_tests++;
    if (tx_valid !== 1'b0 || pkt_cnt !== 3'(m_lens.size()) || buf_free !== 12'(m_free)) begin
      n_fail++;
      $display("FAIL after_read: v %b cnt %0d free %0d want 0 %0d %0d", tx_valid, pkt_cnt,
               buf_free, m_lens.size(), m_free);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00 || wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tx: v %b l %b d %h drop %b want 0 0 00 0", tx_valid, tx_last,
               tx_data, wr_drop);
    end
    n_tests++;
    if (pkt_rdy !== 1'b0 || pkt_len !== 12'd0 || pkt_cnt !== 3'd0 || buf_free !== 12'd2048) begin
      n_fail++;
      $display("FAIL reset_state: rdy %b len %0d cnt %0d free %0d want 0 0 0 2048", pkt_rdy,
               pkt_len, pkt_cnt, buf_free);
    end
    rst = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic test_basic();
    write_pkt(5, 0, 8'h11);
    read_pkt(0);
  endtask

  task automatic test_stall();
    write_pkt(5, 0, 8'h11);
    read_pkt(2);
  endtask

  task automatic test_commit_race();
    wr_en = 1'b1; wr_data = 8'hA5; wr_last = 1'b1; rd_req = 1'b1;
    tick();
    wr_en = 1'b0; wr_last = 1'b0; rd_req = 1'b0;
    m_bytes.push_back(8'hA5); m_lens.push_back(1); m_free -= 1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (tx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL race_no_start: tx_valid %b want 0 (cycle %0d)", tx_valid, i);
      end
      tick();
    end
    read_pkt(0);
  endtask

  // Stream packet A while packet B is written; A's release and B's commit share a cycle.
  task automatic test_concurrent();
    logic [7:0] b_bytes[$];
    logic [7:0] exp_d;
    int         got;
    write_pkt(10, 1, 8'h00);
    got = 0;
    for (int k = 0; k < 12; k++) begin
      rd_req = (k == 0); tx_ready = 1'b1;
      wr_en = 1'b1; wr_data = 8'($urandom); wr_last = (k == 11);
      b_bytes.push_back(wr_data);
      if (tx_valid && tx_ready) begin
        exp_d = m_bytes.pop_front();
        n_tests++;
        if (tx_data !== exp_d || tx_last !== (got == 9)) begin
          n_fail++;
          $display("FAIL conc_byte %0d: data %h last %b want %h %b", got, tx_data, tx_last,
                   exp_d, (got == 9));
        end
        got++;
      end
      tick();
    end
    wr_en = 1'b0; wr_last = 1'b0; rd_req = 1'b0; tx_ready = 1'b0;
    void'(m_lens.pop_front());
    m_free = m_free + 10 - 12;
    m_lens.push_back(12);
    foreach (b_bytes[i]) m_bytes.push_back(b_bytes[i]);
    n_tests++;
    if (got != 10 || tx_valid !== 1'b0 || pkt_cnt !== 3'd1 || buf_free !== 12'(m_free)) begin
      n_fail++;
      $display("FAIL conc_state: got %0d v %b cnt %0d free %0d want 10 0 1 %0d", got, tx_valid,
               pkt_cnt, buf_free, m_free);
    end
    read_pkt(1);
  endtask

  task automatic test_overflow();
    int exp_free;
    write_pkt(2040, 1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom); wr_last = (i == 15);
      tick();
      exp_free = (i < 8) ? 7 - i : 8;
      n_tests++;
      if (buf_free !== 12'(exp_free) || wr_drop !== (i == 15)) begin
        n_fail++;
        $display("FAIL overflow_byte %0d: free %0d drop %b want %0d %b", i + 1, buf_free,
                 wr_drop, exp_free, (i == 15));
      end
    end
    wr_en = 1'b0; wr_last = 1'b0;
    tick();
    n_tests++;
    if (wr_drop !== 1'b0 || buf_free !== 12'd8 || pkt_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL overflow_end: drop %b free %0d cnt %0d want 0 8 1", wr_drop, buf_free,
               pkt_cnt);
    end
    read_pkt(0);
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 5; i++) write_pkt(1, 1, 8'h00);
    while (m_lens.size() > 0) read_pkt(1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) write_pkt(682, 1, 8'h00);
    n_tests++;
    if (pkt_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL b2b_cnt: pkt_cnt %0d want 3", pkt_cnt);
    end
    for (int i = 0; i < 3; i++) read_pkt(0);
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] exp_d;
    int         idx, cyc;
    write_pkt(700, 1, 8'h00);
    rd_req = 1'b1; tx_ready = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    idx = 0; cyc = 0;
    while (idx < 299 && cyc < 400) begin
      if (tx_valid) begin
        exp_d = m_bytes.pop_front();
        n_tests++;
        if (tx_data !== exp_d) begin
          n_fail++;
          $display("FAIL pre_reset_byte %0d: data %h want %h", idx, tx_data, exp_d);
        end
        idx++;
      end
      tick();
      cyc++;
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: v %b d %h want 0 00", tx_valid, tx_data);
    end
    tick();
    n_tests++;
    if (tx_valid !== 1'b0 || pkt_cnt !== 3'd0 || buf_free !== 12'd2048 || pkt_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: v %b cnt %0d free %0d rdy %b want 0 0 2048 0", tx_valid, pkt_cnt,
               buf_free, pkt_rdy);
    end
    rst = 1'b0; tx_ready = 1'b0;
    model_clear();
    tick();
    write_pkt(20, 1, 8'h00);
    read_pkt(1);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 5; it++) begin
      n = 1 + int'($urandom % 4);
      for (int p = 0; p < n; p++) write_pkt(1 + int'($urandom % 700), 1, 8'h00);
      while (m_lens.size() > 0) read_pkt(int'($urandom % 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_commit_race();
    test_concurrent();
    test_overflow();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid_send();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
